// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU control codes (common with ALU_32bit) and the FSM state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath/ALU bundle: instruction fields and status in,
// mux selects, strobes and ALU code out.
interface mips_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero_Flag;
  logic       Mem_Ready;
  logic [2:0] ALU_Control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       PC_En;
  logic       Illegal_Instr;

  modport master (
    input  Opcode, Funct, Zero_Flag, Mem_Ready,
    output ALU_Control, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PC_En, Illegal_Instr
  );

  modport slave (
    output Opcode, Funct, Zero_Flag, Mem_Ready,
    input  ALU_Control, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, PC_En, Illegal_Instr
  );
endinterface

// File: rtl/mips_multicycle_controller_alu_control_decoder.sv
// R-type Funct -> ALU control code; unsupported functs flag illegal and
// fall back to AND.
module alu_control_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = ALU_AND;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_SLT:  alu_control_o = ALU_SLT;
      FN_MUL:  alu_control_o = ALU_MUL;
      default: funct_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the ALU code and datapath strobes, and counts retired instructions.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  mips_ctrl_if.master      ctrl,
  output logic [CNT_W-1:0] Instr_Count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0] dec_alu_s;
  logic       dec_ill_s;
  logic [2:0] alu_s;
  logic       srca_s, iord_s, mem_write_s, ir_write_s, reg_dst_s;
  logic       mem_to_reg_s, reg_write_s, pc_write_s, branch_s, illegal_s, retire_s;
  logic [1:0] srcb_s, pcsrc_s;

  alu_control_decoder u_alu_dec (
    .funct_i         (ctrl.Funct),
    .alu_control_o   (dec_alu_s),
    .funct_illegal_o (dec_ill_s)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_s        = ALU_ADD;
    srca_s       = 1'b0;
    srcb_s       = 2'b00;
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    pcsrc_s      = 2'b00;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        srcb_s = 2'b01;
        if (ctrl.Mem_Ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        srcb_s = 2'b11;
        case (ctrl.Opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        srca_s  = 1'b1;
        srcb_s  = 2'b10;
        state_d = (ctrl.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_s  = 1'b1;
        state_d = ctrl.Mem_Ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = ctrl.Mem_Ready;
        state_d     = ctrl.Mem_Ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC_R: begin
        srca_s    = 1'b1;
        alu_s     = dec_alu_s;
        illegal_s = dec_ill_s;
        state_d   = dec_ill_s ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        srca_s   = 1'b1;
        alu_s    = ALU_SUB;
        pcsrc_s  = 2'b01;
        branch_s = 1'b1;
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDI_EX: begin
        srca_s  = 1'b1;
        srcb_s  = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_s    = 2'b10;
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    count_d = retire_s ? count_q + CNT_W'(1) : count_q;
  end

  // Strobes are gated by RST so a reset mid-instruction silences them at once.
  assign ctrl.ALU_Control   = alu_s;
  assign ctrl.ALUSrcA       = srca_s;
  assign ctrl.ALUSrcB       = srcb_s;
  assign ctrl.IorD          = iord_s;
  assign ctrl.RegDst        = reg_dst_s;
  assign ctrl.MemtoReg      = mem_to_reg_s;
  assign ctrl.PCSrc         = pcsrc_s;
  assign ctrl.MemWrite      = RST & mem_write_s;
  assign ctrl.IRWrite       = RST & ir_write_s;
  assign ctrl.RegWrite      = RST & reg_write_s;
  assign ctrl.PC_En         = RST & (pc_write_s | (branch_s & ctrl.Zero_Flag));
  assign ctrl.Illegal_Instr = RST & illegal_s;
  assign Instr_Count        = count_q;

endmodule
